// File: rtl/execute_mdu.sv
// Execute stage: single-cycle ALU, branch/jump resolution and store formatting, plus an
// optional iterative RV-M unit that stalls the stage through in_ready while it runs.
module execute_mdu #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET       = '0,
  parameter bit              MULDIV_EN   = 1'b1,
  parameter int unsigned     FLUSH_SLOTS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   immediate,
  input  logic              immediate_sel,
  input  logic              alu,
  input  logic              lui,
  input  logic              jal,
  input  logic              jalr,
  input  logic              branch,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              muldiv,
  input  logic [2:0]        alu_operation,
  input  logic              arithsubtype,
  input  logic [4:0]        dest_reg_sel,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_result,
  output logic [4:0]        wb_dest_reg_sel,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_mem_write,
  output logic [XLEN-1:0]   wb_write_address,
  output logic [XLEN/8-1:0] wb_write_byte,
  output logic [XLEN-1:0]   wb_write_data,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              illegal_op,
  output logic              busy
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state;
  logic [SW-1:0]   count;
  logic [1:0]      squash_cnt;
  logic [XLEN-1:0] md_hi, md_lo, md_b, md_a;
  logic [2:0]      md_op;
  logic [4:0]      md_rd;
  logic            md_a_neg, md_b_neg, md_div0;

  logic accept, go;
  assign in_ready = (state == StIdle);
  assign accept   = in_valid && in_ready;
  assign go       = accept && (squash_cnt == 2'd0);

  logic [XLEN-1:0] op2, alu_res, sra_res, addr, res_c, target_c, st_data;
  logic [XLEN:0]   slt_diff, sltu_diff;
  logic [SW-1:0]   shamt;
  logic [OW-1:0]   off;
  logic [NB-1:0]   st_byte;
  logic            st_ok, br_taken, br_ill, wr_c, m2r_c, mem_wr_c, ill_c, redir_c;

  always_comb begin
    op2       = immediate_sel ? immediate : rs2_data;
    shamt     = op2[SW-1:0];
    slt_diff  = {rs1_data[XLEN-1], rs1_data} - {op2[XLEN-1], op2};
    sltu_diff = {1'b0, rs1_data} - {1'b0, op2};
    sra_res   = $signed(rs1_data) >>> shamt;
    case (alu_operation)
      3'd0:    alu_res = arithsubtype ? rs1_data - op2 : rs1_data + op2;
      3'd1:    alu_res = rs1_data << shamt;
      3'd2:    alu_res = {{(XLEN-1){1'b0}}, slt_diff[XLEN]};
      3'd3:    alu_res = {{(XLEN-1){1'b0}}, sltu_diff[XLEN]};
      3'd4:    alu_res = rs1_data ^ op2;
      3'd5:    alu_res = arithsubtype ? sra_res : rs1_data >> shamt;
      3'd6:    alu_res = rs1_data | op2;
      default: alu_res = rs1_data & op2;
    endcase
  end

  always_comb begin
    br_ill = 1'b0;
    case (alu_operation)
      3'd0:    br_taken = (rs1_data == rs2_data);
      3'd1:    br_taken = (rs1_data != rs2_data);
      3'd4:    br_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'd5:    br_taken = !($signed(rs1_data) < $signed(rs2_data));
      3'd6:    br_taken = (rs1_data < rs2_data);
      3'd7:    br_taken = !(rs1_data < rs2_data);
      default: begin br_taken = 1'b0; br_ill = 1'b1; end
    endcase
  end

  // Store lanes: data replicated across the bus, strobe placed by the low address bits.
  always_comb begin
    addr = rs1_data + immediate;
    off  = addr[OW-1:0];
    case (alu_operation)
      3'd0: begin st_byte = NB'(1) << off;  st_data = {NB{rs2_data[7:0]}};        st_ok = 1'b1; end
      3'd1: begin st_byte = NB'(3) << off;  st_data = {(NB/2){rs2_data[15:0]}};   st_ok = !off[0]; end
      3'd2: begin st_byte = NB'(15) << off; st_data = {(NB/4){rs2_data[31:0]}};
                  st_ok = (off[1:0] == 2'b00); end
      3'd3: begin st_byte = '1; st_data = rs2_data; st_ok = (XLEN == 64) && (off == '0); end
      default: begin st_byte = '0; st_data = rs2_data; st_ok = 1'b0; end
    endcase
  end

  always_comb begin
    res_c    = alu_res;
    wr_c     = (dest_reg_sel != 5'd0);
    m2r_c    = 1'b0;
    mem_wr_c = 1'b0;
    ill_c    = 1'b0;
    redir_c  = 1'b0;
    target_c = pc + immediate;
    if (lui) begin
      res_c = immediate;
    end else if (jal || jalr) begin
      res_c   = pc + XLEN'(4);
      redir_c = 1'b1;
      if (jalr) target_c = {addr[XLEN-1:1], 1'b0};
    end else if (branch) begin
      wr_c    = 1'b0;
      ill_c   = br_ill;
      redir_c = br_taken && !br_ill;
    end else if (mem_write) begin
      wr_c     = 1'b0;
      res_c    = addr;
      mem_wr_c = st_ok;
      ill_c    = !st_ok;
    end else if (mem_to_reg) begin
      res_c = addr;
      m2r_c = 1'b1;
    end else if (muldiv) begin
      // Only reached when the M unit is configured out.
      wr_c  = 1'b0;
      ill_c = 1'b1;
    end else if (!alu) begin
      wr_c = 1'b0;
    end
  end

  logic            a_neg_c, b_neg_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] q_s, r_s, md_res;

  always_comb begin
    a_neg_c   = rs1_data[XLEN-1] && (alu_operation inside {3'd1, 3'd2, 3'd4, 3'd6});
    b_neg_c   = rs2_data[XLEN-1] && (alu_operation inside {3'd1, 3'd4, 3'd6});
    mag_a_c   = a_neg_c ? -rs1_data : rs1_data;
    mag_b_c   = b_neg_c ? -rs2_data : rs2_data;
    mul_sum   = {1'b0, md_hi} + {1'b0, md_b & {XLEN{md_lo[0]}}};
    div_trial = {md_hi, md_lo[XLEN-1]} - {1'b0, md_b};
    prod      = {md_hi, md_lo};
    prod_s    = (md_a_neg ^ md_b_neg) ? -prod : prod;
    q_s       = (md_a_neg ^ md_b_neg) ? -md_lo : md_lo;
    r_s       = md_a_neg ? -md_hi : md_hi;
    case (md_op)
      3'd0:                md_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    md_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          md_res = md_div0 ? '1 : q_s;
      default:             md_res = md_div0 ? md_a : r_s;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= StIdle;
      count            <= '0;
      squash_cnt       <= 2'd0;
      busy             <= 1'b0;
      md_hi            <= '0;
      md_lo            <= '0;
      md_b             <= '0;
      md_a             <= '0;
      md_op            <= 3'd0;
      md_rd            <= 5'd0;
      md_a_neg         <= 1'b0;
      md_b_neg         <= 1'b0;
      md_div0          <= 1'b0;
      wb_valid         <= 1'b0;
      wb_result        <= '0;
      wb_dest_reg_sel  <= 5'd0;
      wb_reg_write     <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
      wb_mem_write     <= 1'b0;
      wb_write_address <= '0;
      wb_write_byte    <= '0;
      wb_write_data    <= '0;
      redirect         <= 1'b0;
      redirect_pc      <= RESET;
      illegal_op       <= 1'b0;
    end else begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_mem_write  <= 1'b0;
      redirect      <= 1'b0;
      illegal_op    <= 1'b0;
      case (state)
        StIdle: begin
          if (accept && squash_cnt != 2'd0) squash_cnt <= squash_cnt - 2'd1;
          if (go && muldiv && MULDIV_EN) begin
            state    <= StBusy;
            busy     <= 1'b1;
            count    <= '0;
            md_op    <= alu_operation;
            md_rd    <= dest_reg_sel;
            md_a     <= rs1_data;
            md_a_neg <= a_neg_c;
            md_b_neg <= b_neg_c;
            md_div0  <= (rs2_data == '0);
            md_hi    <= '0;
            // Multiply: md_b is the multiplicand; divide: md_b is the divisor.
            md_b     <= alu_operation[2] ? mag_b_c : mag_a_c;
            md_lo    <= alu_operation[2] ? mag_a_c : mag_b_c;
          end else if (go) begin
            wb_valid         <= 1'b1;
            wb_result        <= res_c;
            wb_dest_reg_sel  <= dest_reg_sel;
            wb_reg_write     <= wr_c;
            wb_mem_to_reg    <= m2r_c;
            wb_mem_write     <= mem_wr_c;
            wb_write_address <= addr;
            wb_write_byte    <= st_byte;
            wb_write_data    <= st_data;
            illegal_op       <= ill_c;
            if (redir_c) begin
              redirect    <= 1'b1;
              redirect_pc <= target_c;
              squash_cnt  <= 2'(FLUSH_SLOTS);
            end
          end
        end
        StBusy: begin
          if (md_op[2]) begin
            if (!div_trial[XLEN]) begin
              md_hi <= div_trial[XLEN-1:0];
              md_lo <= {md_lo[XLEN-2:0], 1'b1};
            end else begin
              md_hi <= {md_hi[XLEN-2:0], md_lo[XLEN-1]};
              md_lo <= {md_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            md_hi <= mul_sum[XLEN:1];
            md_lo <= {mul_sum[0], md_lo[XLEN-1:1]};
          end
          count <= count + 1'b1;
          if (count == SW'(XLEN - 1)) state <= StDone;
        end
        StDone: begin
          wb_valid        <= 1'b1;
          wb_result       <= md_res;
          wb_dest_reg_sel <= md_rd;
          wb_reg_write    <= (md_rd != 5'd0);
          busy            <= 1'b0;
          state           <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
